// File: rtl/instruction_register_mb.sv
// instruction_register_mb: multi-byte instruction register capturing an opcode plus 0..MAX_OPERANDS operand bytes
// Ports: clk/clr (sync active-high clear); Li_bar loads opcode or next operand byte; Ei_bar drives the operand;
// w_bus_data/operand_count in; instruction_bus, w_bus_operand, w_bus_oe, instr_ready, operand_index, count_error out.
module instruction_register_mb #(
   parameter int DATA_WIDTH   = 8,
   parameter int OPCODE_WIDTH = 8,
   parameter int MAX_OPERANDS = 2,
   localparam int CW          = $clog2(MAX_OPERANDS + 1)
) (
   input  logic                               clk,
   input  logic                               clr,
   input  logic                               Li_bar,
   input  logic                               Ei_bar,
   input  logic [DATA_WIDTH-1:0]              w_bus_data,
   input  logic [CW-1:0]                      operand_count,
   output logic [OPCODE_WIDTH-1:0]            instruction_bus,
   output logic [MAX_OPERANDS*DATA_WIDTH-1:0] w_bus_operand,
   output logic                               w_bus_oe,
   output logic                               instr_ready,
   output logic [CW-1:0]                      operand_index,
   output logic                               count_error
);
   typedef enum logic [1:0] {EMPTY, OPERAND, READY} state_t;
   localparam logic [CW-1:0] MAX_N = CW'(MAX_OPERANDS);
   state_t state, nxt;
   logic [MAX_OPERANDS*DATA_WIDTH-1:0] operands;
   logic [CW-1:0] remaining;
   logic load, opcode_load, over, last;
   logic [CW-1:0] n_in;
   assign load        = ~Li_bar;
   assign opcode_load = load & (state != OPERAND);
   assign over        = operand_count > MAX_N;
   assign n_in        = over ? MAX_N : operand_count;
   assign last        = (operand_index + CW'(1)) == remaining;
   always_ff @(posedge clk)
      if (clr) state <= EMPTY;
      else     state <= nxt;
   always_comb begin
      nxt = state;
      if (opcode_load) nxt = (n_in == '0) ? READY : OPERAND;
      else if (load && state == OPERAND && last) nxt = READY;
   end
   always_ff @(posedge clk) begin
      if (clr) begin
         instruction_bus <= '0;
         operands        <= '0;
         operand_index   <= '0;
         remaining       <= '0;
         count_error     <= 1'b0;
      end else if (opcode_load) begin
         instruction_bus <= w_bus_data[DATA_WIDTH-1 -: OPCODE_WIDTH];
         operands        <= '0;
         operand_index   <= '0;
         remaining       <= n_in;
         count_error     <= count_error | over;
      end else if (load && state == OPERAND) begin
         for (int i = 0; i < MAX_OPERANDS; i++)
            if (operand_index == CW'(i)) operands[i*DATA_WIDTH +: DATA_WIDTH] <= w_bus_data;
         operand_index <= operand_index + CW'(1);
      end
   end
   // instr_ready comes straight from the state flop, so it is registered
   assign instr_ready   = state == READY;
   assign w_bus_oe      = instr_ready & ~Ei_bar;
   assign w_bus_operand = w_bus_oe ? operands : '0;
endmodule

// File: tb/tb_instruction_register_mb.sv
// tb_instruction_register_mb: directed self-checking bench for instruction_register_mb
module tb_instruction_register_mb;
   logic clk = 1'b0, clr, Li_bar, Ei_bar;
   logic [7:0] w_bus_data, instruction_bus;
   logic [1:0] operand_count, operand_index;
   logic [15:0] w_bus_operand;
   logic w_bus_oe, instr_ready, count_error;
   int checks = 0, errors = 0;

   instruction_register_mb dut (
      .clk(clk), .clr(clr), .Li_bar(Li_bar), .Ei_bar(Ei_bar),
      .w_bus_data(w_bus_data), .operand_count(operand_count),
      .instruction_bus(instruction_bus), .w_bus_operand(w_bus_operand),
      .w_bus_oe(w_bus_oe), .instr_ready(instr_ready),
      .operand_index(operand_index), .count_error(count_error)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      clr = 1'b1; Li_bar = 1'b0; Ei_bar = 1'b0; w_bus_data = 8'hFF; operand_count = 2'd0;
      tick();
      check("rst_ibus", 32'(instruction_bus), 32'h0);
      check("rst_ready", 32'(instr_ready), 32'h0);
      check("rst_idx", 32'(operand_index), 32'h0);
      check("rst_oe", 32'(w_bus_oe), 32'h0);
      check("rst_operand", 32'(w_bus_operand), 32'h0);
      check("rst_cerr", 32'(count_error), 32'h0);

      clr = 1'b0; Ei_bar = 1'b1; w_bus_data = 8'h76; operand_count = 2'd0;
      tick();
      check("zero_ibus", 32'(instruction_bus), 32'h76);
      check("zero_ready", 32'(instr_ready), 32'h1);
      Li_bar = 1'b1; Ei_bar = 1'b0; #1;
      check("zero_oe", 32'(w_bus_oe), 32'h1);
      check("zero_operand", 32'(w_bus_operand), 32'h0);

      Ei_bar = 1'b1; Li_bar = 1'b0; w_bus_data = 8'hC3; operand_count = 2'd2;
      tick();
      check("two_ibus", 32'(instruction_bus), 32'hC3);
      check("two_ready0", 32'(instr_ready), 32'h0);
      check("two_idx0", 32'(operand_index), 32'h0);
      w_bus_data = 8'h34; operand_count = 2'd0;
      tick();
      check("two_idx1", 32'(operand_index), 32'h1);
      check("two_ready1", 32'(instr_ready), 32'h0);
      Li_bar = 1'b1; Ei_bar = 1'b0; #1;
      check("mid_oe", 32'(w_bus_oe), 32'h0);
      check("mid_operand", 32'(w_bus_operand), 32'h0);
      for (int i = 0; i < 3; i++) tick();
      check("idle_ready", 32'(instr_ready), 32'h0);
      check("idle_idx", 32'(operand_index), 32'h1);
      Ei_bar = 1'b1; Li_bar = 1'b0; w_bus_data = 8'h12;
      tick();
      check("two_ready2", 32'(instr_ready), 32'h1);
      check("two_idx2", 32'(operand_index), 32'h2);
      Li_bar = 1'b1; Ei_bar = 1'b0; #1;
      check("two_operand", 32'(w_bus_operand), 32'h1234);
      check("two_oe", 32'(w_bus_oe), 32'h1);

      Li_bar = 1'b0; w_bus_data = 8'h3E; operand_count = 2'd1; #1;
      check("reload_old", 32'(w_bus_operand), 32'h1234);
      tick();
      check("reload_ibus", 32'(instruction_bus), 32'h3E);
      check("reload_ready", 32'(instr_ready), 32'h0);
      check("reload_oe", 32'(w_bus_oe), 32'h0);
      w_bus_data = 8'h56;
      tick();
      check("reload_ready1", 32'(instr_ready), 32'h1);
      check("reload_idx", 32'(operand_index), 32'h1);
      check("reload_operand", 32'(w_bus_operand), 32'h0056);

      Ei_bar = 1'b1; w_bus_data = 8'h11; operand_count = 2'd3;
      tick();
      check("clamp_cerr", 32'(count_error), 32'h1);
      check("clamp_ready0", 32'(instr_ready), 32'h0);
      w_bus_data = 8'hAA;
      tick();
      check("clamp_ready1", 32'(instr_ready), 32'h0);
      w_bus_data = 8'hBB;
      tick();
      check("clamp_ready2", 32'(instr_ready), 32'h1);
      check("clamp_idx", 32'(operand_index), 32'h2);
      Li_bar = 1'b1; Ei_bar = 1'b0; #1;
      check("clamp_operand", 32'(w_bus_operand), 32'hBBAA);
      Ei_bar = 1'b1; Li_bar = 1'b0; w_bus_data = 8'h76; operand_count = 2'd0;
      tick();
      check("clamp_sticky", 32'(count_error), 32'h1);
      check("clamp_ready_n0", 32'(instr_ready), 32'h1);

      w_bus_data = 8'hC3; operand_count = 2'd2;
      tick();
      w_bus_data = 8'h34;
      tick();
      check("mclr_idx1", 32'(operand_index), 32'h1);
      clr = 1'b1; Li_bar = 1'b1;
      tick();
      check("mclr_idx", 32'(operand_index), 32'h0);
      check("mclr_ready", 32'(instr_ready), 32'h0);
      check("mclr_cerr", 32'(count_error), 32'h0);
      check("mclr_ibus", 32'(instruction_bus), 32'h0);
      clr = 1'b0; Ei_bar = 1'b0; #1;
      check("mclr_oe", 32'(w_bus_oe), 32'h0);
      check("mclr_operand", 32'(w_bus_operand), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/instruction_register_mb.md
# instruction_register_mb

Multi-byte instruction register for the SAP-2-class datapath. It captures an opcode byte from the W-bus, then collects 0..MAX_OPERANDS operand bytes. The operand count is supplied by the controller's decode for that opcode. It presents the opcode to the controller and drives the assembled operand back onto the W-bus on request. It sits between the W-bus and the controller/sequencer, in the slot the single-byte instruction register occupies in SAP-1.

## Interface
Parameters:
- DATA_WIDTH, 8, W-bus width in bits
- OPCODE_WIDTH, 8, opcode width; taken from w_bus_data[DATA_WIDTH-1 -: OPCODE_WIDTH]; must be ≤ DATA_WIDTH
- MAX_OPERANDS, 2, maximum operand bytes per instruction (≥1)

Ports:
- Reset is synchronous and active-high, on one clock (clk).
- clk  in  1  rising-edge clock
- clr  in  1  synchronous active-high clear
- Li_bar  in  1  active-low load strobe (opcode or next operand byte)
- Ei_bar  in  1  active-low operand enable onto W-bus
- w_bus_data  in  DATA_WIDTH  W-bus input
- operand_count  in  CW=$clog2(MAX_OPERANDS+1)  operand bytes for the opcode on w_bus_data; sampled only on opcode loads
- instruction_bus  out  OPCODE_WIDTH  current opcode to controller
- w_bus_operand  out  MAX_OPERANDS*DATA_WIDTH  assembled operand; byte 0 in bits [DATA_WIDTH-1:0]; zero when w_bus_oe=0
- w_bus_oe  out  1  operand driven this cycle
- instr_ready  out  1  opcode and all operands captured
- operand_index  out  CW  number of operand bytes captured so far
- count_error  out  1  sticky: an operand_count > MAX_OPERANDS was sampled

## Operation
- States: EMPTY, OPERAND, READY.
- Reset:
  - clr=1 at a rising edge forces state EMPTY.
  - All outputs go to 0: instruction_bus, operand storage, operand_index, instr_ready, count_error.
  - clr overrides Li_bar in the same cycle.
- EMPTY, Li_bar=0:
  - Opcode register ← opcode field; operand storage ← 0; operand_index ← 0.
  - n = min(operand_count, MAX_OPERANDS) is stored as the remaining count.
  - n=0 → READY; otherwise → OPERAND.
- OPERAND, Li_bar=0:
  - Operand byte slot[operand_index] ← w_bus_data; operand_index++.
  - When operand_index reaches n → READY.
  - operand_count is ignored in this state.
- READY, Li_bar=0:
  - Treated as a new opcode load, identical to the EMPTY load. The old operands are cleared.
- Li_bar=1: all registers hold in every state.
- Operand driving (combinational):
  - w_bus_oe = (state==READY) & ~Ei_bar.
  - w_bus_operand = operand storage when w_bus_oe=1, else all zeros.
  - Ei_bar=0 in EMPTY or OPERAND is ignored: oe stays 0 and there is no error.
- instr_ready = (state==READY), registered.
- count_error:
  - Set when operand_count > MAX_OPERANDS is sampled on an opcode load.
  - Cleared only by clr. Clamping applies regardless.
- Unfilled high operand slots (n < MAX_OPERANDS) read as zero, giving zero-extension.
- No latches; all storage is flip-flops on clk.

## Timing
- Opcode load at edge N: instruction_bus is valid after N, with zero-cycle hold beyond that.
- If n=0, instr_ready=1 after N.
- With n operands loaded at edges N+a1..N+an (any gaps allowed), instr_ready rises after the edge that captures the last byte. The minimum is n+1 cycles from the opcode load.
- operand_index updates after each capturing edge.
- instr_ready drops on the edge that loads a new opcode when the new n>0. It stays 1 when the new n=0.
- w_bus_oe and w_bus_operand follow Ei_bar combinationally within the same cycle, with no registered delay.
- Simultaneous Li_bar=0 and Ei_bar=0 in READY:
  - During that cycle, the old operand is driven.
  - The new opcode is captured at the edge.
  - After the edge, the state reflects the new instruction.
- clr during OPERAND (mid-collection) abandons the partial instruction and returns to EMPTY next cycle.

## Test plan
- Reset: drive clr=1 with Li_bar=0 and w_bus_data=8'hFF → after the edge: instruction_bus=0, instr_ready=0, operand_index=0, w_bus_oe=0 even with Ei_bar=0.
- Zero-operand opcode: load 8'h76 with operand_count=0 → instruction_bus=8'h76 and instr_ready=1 one cycle later; Ei_bar=0 → w_bus_operand=0, w_bus_oe=1.
- Two-operand: load 8'hC3 with count 2, then 8'h34, idle 3 cycles, then 8'h12:
  - instr_ready=0 until the 8'h12 edge, then 1.
  - Ei_bar=0 → w_bus_operand=16'h1234.
  - Ei_bar=0 issued mid-collection → w_bus_oe=0.
- Clamp: operand_count=3 with MAX_OPERANDS=2 → count_error=1; ready after 2 operand bytes; count_error persists across a following valid load and clears only on clr.
- Reload from READY: with operand 16'h1234 ready, load 8'h3E with count 1 and 8'h56:
  - In the opcode-load cycle with Ei_bar=0, the bus shows 16'h1234.
  - Afterwards, w_bus_operand=16'h0056.
- Mid-operand clr: after the opcode and 1 of 2 bytes, assert clr → EMPTY, operand_index=0; a following Ei_bar=0 gives w_bus_oe=0.
